motor_cmd_ramp: RTL

Command-shaping stage that sits directly upstream of the `Motor` PWM/H-bridge driver and supplies its `dir` and `speed` inputs. It replaces the raw switch-to-`dir` and constant-speed wiring with a rate-limited speed ramp. It also enforces a stop-and-dwell sequence before any direction change, so the H-bridge never reverses while the motors are driven. One instance serves both wheels.

---
 rtl/motor_cmd_ramp.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/motor_cmd_ramp.sv
// motor_cmd_ramp: rate-limited speed ramp plus a stop-and-dwell sequence for
// direction changes. It drives the dir/speed inputs of the Motor H-bridge
// driver, so the bridge is never reversed while the motors are driven.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req_dir    requested direction (00 stop, 01 fwd, 10 rev, 11 spin), level
//   req_speed  requested duty 0..1023, level
//   estop      emergency stop, level, overrides everything
//   dir        registered direction to Motor.dir
//   speed      registered duty to Motor.speed
//   busy       high while stopping/dwelling or while speed differs from target
module motor_cmd_ramp #(
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 10,
  parameter int DEAD_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_dir,
  input  logic [9:0] req_speed,
  input  logic       estop,
  output logic [1:0] dir,
  output logic [9:0] speed,
  output logic       busy
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW_W  = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  // Dwell count holds "ticks seen minus one"; the last one ends the dwell.
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DEAD_TICKS - 1);
  localparam logic [10:0]      STEP11  = 11'(STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DOWN, S_DWELL} state_t;

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [9:0]       speed_q, speed_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             tick;
  logic             do_ramp;
  logic [9:0]       tgt;
  logic [9:0]       busy_tgt;

  // One step toward tgt, never overshooting. Done in 11 bits so cur+STEP
  // cannot wrap before the comparison.
  function automatic logic [9:0] ramp(input logic [9:0] cur, input logic [9:0] goal);
    logic [10:0] c;
    logic [10:0] g;
    c = {1'b0, cur};
    g = {1'b0, goal};
    if (c < g)      ramp = ((g - c) > STEP11) ? 10'(c + STEP11) : goal;
    else if (c > g) ramp = ((c - g) > STEP11) ? 10'(c - STEP11) : goal;
    else            ramp = cur;
  endfunction

  // Free-running tick divider, unaffected by state changes.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    dwell_d = dwell_q;
    tgt     = 10'd0;
    do_ramp = 1'b0;
    if (estop) begin
      state_d = S_DWELL;
      dir_d   = 2'b00;
      speed_d = 10'd0;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          dir_d   = 2'b00;
          speed_d = 10'd0;
          if (req_dir != 2'b00) begin
            dir_d   = req_dir;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // A direction change retargets to 0 in this very cycle.
          do_ramp = 1'b1;
          if (req_dir == dir_q) tgt = req_speed;
          else                  state_d = S_DOWN;
        end
        S_DOWN: begin
          if (req_dir == dir_q && req_dir != 2'b00) begin
            state_d = S_RUN;
            tgt     = req_speed;
            do_ramp = 1'b1;
          end else if (speed_q == 10'd0) begin
            state_d = S_DWELL;
            dir_d   = 2'b00;
            dwell_d = '0;
          end else begin
            do_ramp = 1'b1;
          end
        end
        S_DWELL: begin
          dir_d   = 2'b00;
          speed_d = 10'd0;
          if (tick) begin
            if (dwell_q == DW_LAST) begin
              state_d = S_IDLE;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (do_ramp && tick) speed_d = ramp(speed_q, tgt);
    end

    // busy reflects the state/speed being registered on this edge. A pending
    // nonzero request in IDLE keeps it high across the IDLE->RUN hop.
    case (state_d)
      S_RUN:   busy_tgt = req_speed;
      S_IDLE:  busy_tgt = (req_dir != 2'b00) ? req_speed : 10'd0;
      default: busy_tgt = 10'd0;
    endcase
    busy_d = (state_d == S_DOWN) || (state_d == S_DWELL) || (speed_d != busy_tgt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= 2'b00;
      speed_q <= 10'd0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  assign dir   = dir_q;
  assign speed = speed_q;
  assign busy  = busy_q;

endmodule
